// File: rtl/cmd_parser_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cmd_parser_fifo
// Brief    : ASCII keystroke parser that validates decimal command lines against
//            the game context and queues legal command words for the engine.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_parser_fifo #(
    parameter int DEPTH      = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_byte,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     on_enemy,
    input  logic                     hacks_en,
    output logic [15:0]              cmd_data,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic                     err_pulse,
    output logic [1:0]               err_code,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_FCNT_W = c_PTR_W + 1;
    localparam int c_DCNT_W = $clog2(MAX_DIGITS + 1);

    localparam logic [c_DCNT_W-1:0] c_MAX_CNT  = c_DCNT_W'(MAX_DIGITS);
    localparam logic [c_FCNT_W-1:0] c_FULL_CNT = c_FCNT_W'(DEPTH);

    localparam logic [1:0] c_ERR_BAD  = 2'd0;
    localparam logic [1:0] c_ERR_OVF  = 2'd1;
    localparam logic [1:0] c_ERR_ILL  = 2'd2;
    localparam logic [1:0] c_ERR_FULL = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIGITS  = 2'd1,
        S_DISCARD = 2'd2,
        S_EMIT    = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [9:0]             r_acc;
    logic [9:0]             w_acc_next;
    logic [c_DCNT_W-1:0]    r_cnt;
    logic [c_DCNT_W-1:0]    w_cnt_next;

    logic                   r_err_pulse;
    logic [1:0]             r_err_code;
    logic                   w_err;
    logic [1:0]             w_err_code;

    logic [15:0]            r_mem [DEPTH];
    logic [c_PTR_W-1:0]     r_wptr;
    logic [c_PTR_W-1:0]     r_rptr;
    logic [c_FCNT_W-1:0]    r_count;
    logic [15:0]            r_last;

    logic                   w_take;
    logic                   w_is_digit;
    logic                   w_is_term;
    logic                   w_is_space;
    logic [9:0]             w_digit;
    logic                   w_legal;
    logic                   w_room;
    logic                   w_push;
    logic                   w_pop;
    logic [15:0]            w_cmd_word;

    // ------------------------------------------------------------------------
    // Character classification
    // ------------------------------------------------------------------------
    assign w_take     = in_valid && in_ready;
    assign w_is_digit = (in_byte >= 8'h30) && (in_byte <= 8'h39);
    assign w_is_term  = (in_byte == 8'h0A) || (in_byte == 8'h0D);
    assign w_is_space = (in_byte == 8'h20);
    assign w_digit    = {6'd0, in_byte[3:0]};

    // ------------------------------------------------------------------------
    // Context legality and command encoding of the latched value
    // ------------------------------------------------------------------------
    assign w_legal = ((r_acc >= 10'd1) && (r_acc <= 10'd4) && !on_enemy)
                  || (((r_acc == 10'd5) || (r_acc == 10'd6)) && on_enemy)
                  || ((r_acc == 10'd10) && hacks_en);

    assign w_cmd_word = (r_acc == 10'd10) ? 16'h0010 : {6'd0, r_acc};

    assign cmd_valid = (r_count != '0);
    assign w_pop     = cmd_valid && cmd_ready;
    // A full FIFO still has room when the head leaves in the same cycle.
    assign w_room    = (r_count < c_FULL_CNT) || ((r_count == c_FULL_CNT) && w_pop);

    // ------------------------------------------------------------------------
    // Parser state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_err        = 1'b0;
        w_err_code   = c_ERR_BAD;
        w_push       = 1'b0;
        in_ready     = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    if (w_is_digit) begin
                        w_acc_next   = w_digit;
                        w_cnt_next   = c_DCNT_W'(1);
                        w_state_next = S_DIGITS;
                    end else if (!w_is_term && !w_is_space) begin
                        w_err        = 1'b1;
                        w_err_code   = c_ERR_BAD;
                        w_state_next = S_DISCARD;
                    end
                end
            end

            S_DIGITS: begin
                if (w_take) begin
                    if (w_is_digit) begin
                        if (r_cnt < c_MAX_CNT) begin
                            w_acc_next = (r_acc * 10'd10) + w_digit;
                            w_cnt_next = r_cnt + c_DCNT_W'(1);
                        end else begin
                            w_err        = 1'b1;
                            w_err_code   = c_ERR_OVF;
                            w_state_next = S_DISCARD;
                        end
                    end else if (w_is_term) begin
                        w_state_next = S_EMIT;
                    end else if (!w_is_space) begin
                        w_err        = 1'b1;
                        w_err_code   = c_ERR_BAD;
                        w_state_next = S_DISCARD;
                    end
                end
            end

            S_DISCARD: begin
                if (w_take && w_is_term) begin
                    w_state_next = S_IDLE;
                end
            end

            S_EMIT: begin
                in_ready     = 1'b0;
                w_state_next = S_IDLE;
                if (!w_legal) begin
                    w_err      = 1'b1;
                    w_err_code = c_ERR_ILL;
                end else if (!w_room) begin
                    w_err      = 1'b1;
                    w_err_code = c_ERR_FULL;
                end else begin
                    w_push = 1'b1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Error reporting: pulse for one cycle, code sticks until the next pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_pulse <= 1'b0;
            r_err_code  <= c_ERR_BAD;
        end else begin
            r_err_pulse <= w_err;
            if (w_err) begin
                r_err_code <= w_err_code;
            end
        end
    end

    assign err_pulse = r_err_pulse;
    assign err_code  = r_err_code;

    // ------------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_cmd_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_last  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
                r_last <= r_mem[r_rptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_FCNT_W'(1);
                2'b01:   r_count <= r_count - c_FCNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // An empty FIFO keeps showing the most recently consumed word.
    assign cmd_data   = cmd_valid ? r_mem[r_rptr] : r_last;
    assign fifo_count = r_count;

endmodule
`default_nettype wire
